// File: rtl/fft_sram_arbiter.sv
// Sample-SRAM arbiter for the FFT datapath: loader, FFT engine and host share one port.
// Optional FFT_ARB_ERRCNT_EN adds a saturating err_cnt[7:0] output.
module fft_sram_arbiter #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_start,
    input  logic              fft_req,
    input  logic              fft_we,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [DATA_W-1:0] fft_wdata,
    input  logic              fft_done,
    input  logic              host_rd,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              fft_gnt,
    output logic              host_gnt,
    output logic              fft_rvalid,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        phase,
    output logic              fft_go,
    output logic              err,
    output logic [ADDR_W-1:0] load_cnt
`ifdef FFT_ARB_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StDone = 2'b11
    } phase_e;

    localparam logic [ADDR_W-1:0] FrameLen = ADDR_W'(FRAME_LEN);

    phase_e            state_q;
    logic [ADDR_W-1:0] load_cnt_q;
    logic              fft_go_q;
    logic              err_q;
    logic              rvalid_q;
    logic              tag_fft_q;

    logic in_run;
    logic load_gnt;
    logic cnt_full;
    logic start_ok;
    logic start_err;
    logic run_reject;

    // Loader beats host outside RUN; the FFT engine owns the port in RUN.
    always_comb begin
        in_run     = (state_q == StRun);
        load_gnt   = !rst && load_we && !in_run;
        host_gnt   = !rst && host_rd && !load_we && !in_run;
        fft_gnt    = !rst && fft_req && in_run;
        cnt_full   = (load_cnt_q == FrameLen);
        start_ok   = (state_q == StLoad) && load_start && cnt_full;
        start_err  = (state_q == StLoad) && load_start && !cnt_full;
        run_reject = in_run && (load_we || host_rd);

        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (load_gnt) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = load_addr;
            sram_wdata = load_data;
        end else if (host_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = host_addr;
        end else if (fft_gnt) begin
            sram_en    = 1'b1;
            sram_we    = fft_we;
            sram_addr  = fft_addr;
            sram_wdata = fft_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            fft_go_q   <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            tag_fft_q  <= 1'b0;
        end else begin
            fft_go_q <= 1'b0;
            err_q    <= start_err || run_reject;
            rvalid_q <= host_gnt || (fft_gnt && !fft_we);
            if (host_gnt || fft_gnt) begin
                tag_fft_q <= fft_gnt;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (load_gnt) begin
                        state_q    <= StLoad;
                        load_cnt_q <= ADDR_W'(1);
                    end
                end
                StLoad: begin
                    if (start_ok) begin
                        state_q    <= StRun;
                        load_cnt_q <= '0;
                        fft_go_q   <= 1'b1;
                    end else if (load_gnt && !cnt_full) begin
                        load_cnt_q <= load_cnt_q + ADDR_W'(1);
                    end
                end
                StRun: begin
                    if (fft_done) begin
                        state_q <= StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase       = state_q;
    assign load_cnt    = load_cnt_q;
    assign fft_go      = fft_go_q;
    assign err         = err_q;
    assign fft_rvalid  = rvalid_q && tag_fft_q;
    assign host_rvalid = rvalid_q && !tag_fft_q;
    assign rdata       = rvalid_q ? sram_rdata : '0;

`ifdef FFT_ARB_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/fft_sram_arbiter.md
FFT_SRAM_ARBITER -- requirements
Module: fft_sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the sample SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the sample SRAM data width.
REQ-003 The block SHALL have parameter FRAME_LEN, default 256, giving the number of loader writes that make one complete frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port load_we, input, 1 bit: loader write request, qualified with load_addr[ADDR_W-1:0] and load_data[DATA_W-1:0].
REQ-007 The block SHALL have port load_start, input, 1 bit: loader frame-complete pulse requesting an FFT run.
REQ-008 The block SHALL have port fft_req, input, 1 bit: FFT engine access request, qualified with fft_we, fft_addr[ADDR_W-1:0] and fft_wdata[DATA_W-1:0].
REQ-009 The block SHALL have port fft_done, input, 1 bit: FFT engine completion pulse.
REQ-010 The block SHALL have port host_rd, input, 1 bit: host readback request, qualified with host_addr[ADDR_W-1:0].
REQ-011 The block SHALL have the SRAM-side ports: sram_en (output, 1 bit), sram_we (output, 1 bit), sram_addr (output, ADDR_W bits), sram_wdata (output, DATA_W bits) and sram_rdata (input, DATA_W bits).
REQ-012 The block SHALL have grant and return ports: fft_gnt, host_gnt, fft_rvalid and host_rvalid (outputs, 1 bit each) and rdata (output, DATA_W bits).
REQ-013 The block SHALL have status ports: phase (output, 2 bits), fft_go (output, 1 bit), err (output, 1 bit) and load_cnt (output, ADDR_W bits).

Function
REQ-014 The phase FSM SHALL have four states: IDLE=00, LOAD=01, RUN=10 and DONE=11, and phase SHALL equal the current state.
REQ-015 In IDLE, LOAD or DONE, an asserted load_we SHALL be granted in the same cycle; the grant drives sram_en=1, sram_we=1, sram_addr=load_addr and sram_wdata=load_data combinationally.
REQ-016 A granted loader write in IDLE or DONE SHALL move the FSM to LOAD and set load_cnt to 1.
REQ-017 A granted loader write in LOAD SHALL increment load_cnt, saturating at FRAME_LEN.
REQ-018 load_start in LOAD with load_cnt==FRAME_LEN SHALL move the FSM to RUN, clear load_cnt and pulse fft_go for exactly one cycle on entry to RUN.
REQ-019 load_start in LOAD with load_cnt!=FRAME_LEN SHALL pulse err for one cycle and leave the FSM in LOAD.
REQ-020 load_start in IDLE, RUN or DONE SHALL be ignored.
REQ-021 In RUN, fft_gnt SHALL equal fft_req combinationally, and the SRAM SHALL be driven from the fft_* inputs.
REQ-022 In RUN, any load_we or host_rd SHALL be rejected (no grant) and SHALL pulse err on the following cycle.
REQ-023 fft_done in RUN SHALL move the FSM to DONE; fft_done in any other state SHALL be ignored.
REQ-024 host_rd SHALL be granted in IDLE, LOAD or DONE only when load_we is low in the same cycle; a simultaneous loader write wins and host_gnt stays 0, so the host holds its request.
REQ-025 Read latency SHALL be 1 cycle: a granted read with sram_we=0 SHALL assert exactly one of fft_rvalid or host_rvalid on the next cycle, selected by a registered requester tag, with rdata=sram_rdata in that cycle.
REQ-026 When no request is granted, sram_en, sram_we, sram_addr and sram_wdata SHALL all be 0.
REQ-027 An FFT write (fft_we=1) SHALL produce no rvalid pulse.
REQ-028 err SHALL be a registered, 1-cycle pulse, and multiple error causes in the same cycle SHALL produce a single pulse.

Reset
REQ-029 While rst is high at a clock edge, the FSM SHALL enter IDLE, load_cnt, fft_go, err, fft_rvalid, host_rvalid and the requester tag SHALL clear to 0, and all grants SHALL be 0.
REQ-030 rst asserted mid-RUN SHALL abandon the run with no fft_go or rvalid pulse afterwards, and the first cycle after reset SHALL accept a loader write.

Configuration
REQ-031 With FFT_ARB_ERRCNT_EN defined, the block SHALL add output err_cnt[7:0], which increments on each err pulse, saturates at 255, clears on reset, and is not cleared by phase changes.
REQ-032 Without FFT_ARB_ERRCNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 The bench SHALL cover: 256 load_we writes (addr 0..255, data=addr) then load_start -> phase 01→10, fft_go high for exactly 1 cycle, load_cnt=0.
REQ-034 The bench SHALL cover: 100 loader writes then load_start -> err pulses once, phase stays 01, load_cnt=100.
REQ-035 The bench SHALL cover: in RUN, fft_req with fft_we=0 and fft_addr=5 returning sram_rdata=16'h1234 -> fft_gnt same cycle, fft_rvalid and rdata=16'h1234 next cycle, host_rvalid=0.
REQ-036 The bench SHALL cover: in RUN, load_we and host_rd asserted in the same cycle -> no grants, sram_en=0, one err pulse.
REQ-037 The bench SHALL cover: in DONE, host_rd and load_we asserted simultaneously -> write granted, host_gnt=0, phase→01; in the next cycle host_rd alone -> host_gnt=1 and host_rvalid one cycle later.
REQ-038 The bench SHALL cover: rst pulsed mid-RUN with fft_req high -> phase=00, all outputs 0, and no fft_go in any later cycle until a new full frame is loaded.
